// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, datapath mux encodings and state-to-control decode
// shared by the main FSM, the datapath and the bench.
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BRANCH, FAULT
    } mc_state_t;

    localparam logic [1:0] SRCA_RN       = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT   = 2'b10;
    localparam logic [1:0] SRCB_RM       = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       fetch;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       adr_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res_src;
        logic       fault;
    } mc_ctrl_t;

    function automatic mc_ctrl_t ctrl_decode(mc_state_t s);
        mc_ctrl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.mem_req = 1'b1; c.fetch = 1'b1; c.src_a = SRCA_PC; c.src_b = SRCB_FOUR; c.res_src = RES_ALURESULT; end
            DECODE: begin c.src_a = SRCA_PC; c.src_b = SRCB_FOUR; c.res_src = RES_ALURESULT; end
            MEMADR: c.src_b = SRCB_EXTIMM;
            MEMRD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            MEMWR:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_w = 1'b1; end
            MEMWB:  begin c.res_src = RES_DATA; c.reg_w = 1'b1; end
            EXECR:  c.alu_op = 1'b1;
            EXECI:  begin c.src_b = SRCB_EXTIMM; c.alu_op = 1'b1; end
            ALUWB:  c.reg_w = 1'b1;
            BRANCH: begin c.src_a = SRCA_ALUOUT; c.src_b = SRCB_EXTIMM; c.res_src = RES_ALURESULT; c.branch = 1'b1; end
            FAULT:  c.fault = 1'b1;
            default: ;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles and flags expiry at TIMEOUT
// (TIMEOUT == 0 never expires).
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);
    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset || i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expire = (TIMEOUT > 0) && (r_cnt == TMR_W'(TIMEOUT));
endmodule

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multicycle ARM-subset main controller with variable-latency
// memory handshake, timeout-to-FAULT and a retired-instruction counter.
module mc_main_fsm
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             ALUOp,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);
    mc_state_t        r_state, w_next;
    mc_ctrl_t         r_ctrl;
    logic [CNT_W-1:0] r_cnt;
    logic             w_expire, w_retire, w_unused;

    assign w_unused = ^Funct[4:1];

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:  w_next = mem_ready ? DECODE : (w_expire ? FAULT : FETCH);
            DECODE: w_next = (Op == 2'b00) ? (Funct[5] ? EXECI : EXECR) :
                             (Op == 2'b01) ? MEMADR : (Op == 2'b10) ? BRANCH : FAULT;
            MEMADR: w_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  w_next = mem_ready ? MEMWB : (w_expire ? FAULT : MEMRD);
            MEMWR:  w_next = mem_ready ? FETCH : (w_expire ? FAULT : MEMWR);
            EXECR, EXECI:         w_next = ALUWB;
            MEMWB, ALUWB, BRANCH: w_next = FETCH;
            default: w_next = FAULT;
        endcase
    end

    assign w_retire = (r_state == MEMWB) || (r_state == ALUWB) || (r_state == BRANCH) ||
                      ((r_state == MEMWR) && mem_ready);

    // A state change marks entry to a new access (or its completion), so it restarts the wait count.
    mem_wait_timer #(.TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_next != r_state),
        .i_inc    (r_ctrl.mem_req && !mem_ready),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FETCH;
            r_ctrl  <= ctrl_decode(FETCH);
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_decode(w_next);
            r_cnt   <= r_cnt + CNT_W'(w_retire);
        end
    end

    assign mem_req   = r_ctrl.mem_req;
    assign IRWrite   = r_ctrl.fetch && mem_ready;
    assign NextPC    = r_ctrl.fetch && mem_ready;
    assign RegW      = r_ctrl.reg_w;
    assign MemW      = r_ctrl.mem_w;
    assign Branch    = r_ctrl.branch;
    assign ALUOp     = r_ctrl.alu_op;
    assign AdrSrc    = r_ctrl.adr_src;
    assign ALUSrcA   = r_ctrl.src_a;
    assign ALUSrcB   = r_ctrl.src_b;
    assign ResultSrc = r_ctrl.res_src;
    assign fault     = r_ctrl.fault;
    assign instr_cnt = r_cnt;
endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: directed scoreboard bench; each driven cycle queues the
// expected control word, a negedge monitor pops and compares it.
module tb_mc_main_fsm;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] instr_cnt;

    typedef struct {
        logic        chk;
        logic [18:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mc_main_fsm #(.TIMEOUT(15), .TMR_W(4), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .fault     (fault),
        .instr_cnt (instr_cnt)
    );

    // {mem_req, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, fault, instr_cnt}
    function automatic logic [18:0] ev(mc_state_t s, logic r, logic [3:0] c);
        logic [14:0] v;
        case (s)
            FETCH:   v = {1'b1, r, r, 5'b00000, 2'b01, 2'b10, 2'b10, 1'b0};
            DECODE:  v = {3'b000, 5'b00000, 2'b01, 2'b10, 2'b10, 1'b0};
            MEMADR:  v = {3'b000, 5'b00000, 2'b00, 2'b01, 2'b00, 1'b0};
            MEMRD:   v = {3'b100, 5'b00001, 2'b00, 2'b00, 2'b00, 1'b0};
            MEMWR:   v = {3'b100, 5'b01001, 2'b00, 2'b00, 2'b00, 1'b0};
            MEMWB:   v = {3'b000, 5'b10000, 2'b00, 2'b00, 2'b01, 1'b0};
            EXECR:   v = {3'b000, 5'b00010, 2'b00, 2'b00, 2'b00, 1'b0};
            EXECI:   v = {3'b000, 5'b00010, 2'b00, 2'b01, 2'b00, 1'b0};
            ALUWB:   v = {3'b000, 5'b10000, 2'b00, 2'b00, 2'b00, 1'b0};
            BRANCH:  v = {3'b000, 5'b00100, 2'b10, 2'b01, 2'b10, 1'b0};
            default: v = {14'b0, 1'b1};
        endcase
        return {v, c};
    endfunction

    task automatic cyc(input logic [1:0] op, input logic [5:0] f, input logic rdy,
                       input logic rst_n, input logic chk, input mc_state_t st,
                       input logic [3:0] c, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        Op = op;
        Funct = f;
        mem_ready = rdy;
        reset = rst_n;
        e.chk = chk;
        e.exp = ev(st, rdy, c);
        e.name = name;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [18:0] got;
            e = q.pop_front();
            got = {mem_req, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, fault, instr_cnt};
            if (e.chk) begin
                n_cmp++;
                if (got !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got=%05h expected=%05h", e.name, got, e.exp);
                end
            end
        end
    end

    initial begin
        cyc(2'd0, 6'h00, 1'b0, 1'b0, 1'b0, FETCH, 4'd0, "rst_hold");
        cyc(2'd0, 6'h00, 1'b0, 1'b0, 1'b1, FETCH, 4'd0, "rst_hold");
        cyc(2'd0, 6'h00, 1'b0, 1'b1, 1'b1, FETCH, 4'd0, "rst_release");
        // ADD register
        cyc(2'd0, 6'h04, 1'b1, 1'b1, 1'b1, FETCH,  4'd0, "add_fetch");
        cyc(2'd0, 6'h04, 1'b0, 1'b1, 1'b1, DECODE, 4'd0, "add_decode");
        cyc(2'd0, 6'h04, 1'b0, 1'b1, 1'b1, EXECR,  4'd0, "add_execr");
        cyc(2'd0, 6'h04, 1'b0, 1'b1, 1'b1, ALUWB,  4'd0, "add_aluwb");
        // LDR with 3 stall cycles
        cyc(2'd1, 6'h01, 1'b1, 1'b1, 1'b1, FETCH,  4'd1, "ldr_fetch");
        cyc(2'd1, 6'h01, 1'b0, 1'b1, 1'b1, DECODE, 4'd1, "ldr_decode");
        cyc(2'd1, 6'h01, 1'b0, 1'b1, 1'b1, MEMADR, 4'd1, "ldr_memadr");
        for (int i = 0; i < 3; i++)
            cyc(2'd1, 6'h01, 1'b0, 1'b1, 1'b1, MEMRD, 4'd1, "ldr_memrd_wait");
        cyc(2'd1, 6'h01, 1'b1, 1'b1, 1'b1, MEMRD,  4'd1, "ldr_memrd_ready");
        cyc(2'd1, 6'h01, 1'b0, 1'b1, 1'b1, MEMWB,  4'd1, "ldr_memwb");
        // ADD immediate
        cyc(2'd0, 6'h28, 1'b1, 1'b1, 1'b1, FETCH,  4'd2, "addi_fetch");
        cyc(2'd0, 6'h28, 1'b0, 1'b1, 1'b1, DECODE, 4'd2, "addi_decode");
        cyc(2'd0, 6'h28, 1'b0, 1'b1, 1'b1, EXECI,  4'd2, "addi_execi");
        cyc(2'd0, 6'h28, 1'b0, 1'b1, 1'b1, ALUWB,  4'd2, "addi_aluwb");
        // STR with one stall cycle
        cyc(2'd1, 6'h00, 1'b1, 1'b1, 1'b1, FETCH,  4'd3, "str_fetch");
        cyc(2'd1, 6'h00, 1'b0, 1'b1, 1'b1, DECODE, 4'd3, "str_decode");
        cyc(2'd1, 6'h00, 1'b0, 1'b1, 1'b1, MEMADR, 4'd3, "str_memadr");
        cyc(2'd1, 6'h00, 1'b0, 1'b1, 1'b1, MEMWR,  4'd3, "str_memwr_wait");
        cyc(2'd1, 6'h00, 1'b1, 1'b1, 1'b1, MEMWR,  4'd3, "str_memwr_ready");
        // LDR whose ready lands exactly when the wait count reaches TIMEOUT
        cyc(2'd1, 6'h01, 1'b1, 1'b1, 1'b1, FETCH,  4'd4, "edge_fetch");
        cyc(2'd1, 6'h01, 1'b0, 1'b1, 1'b1, DECODE, 4'd4, "edge_decode");
        cyc(2'd1, 6'h01, 1'b0, 1'b1, 1'b1, MEMADR, 4'd4, "edge_memadr");
        for (int i = 0; i < 15; i++)
            cyc(2'd1, 6'h01, 1'b0, 1'b1, 1'b1, MEMRD, 4'd4, "edge_memrd_wait");
        cyc(2'd1, 6'h01, 1'b1, 1'b1, 1'b1, MEMRD,  4'd4, "edge_memrd_ready");
        cyc(2'd1, 6'h01, 1'b0, 1'b1, 1'b1, MEMWB,  4'd4, "edge_memwb");
        // illegal Op
        cyc(2'd3, 6'h00, 1'b1, 1'b1, 1'b1, FETCH,  4'd5, "ill_fetch");
        cyc(2'd3, 6'h00, 1'b0, 1'b1, 1'b1, DECODE, 4'd5, "ill_decode");
        for (int i = 0; i < 3; i++)
            cyc(2'd0, 6'h00, 1'b1, 1'b1, 1'b1, FAULT, 4'd5, "ill_fault");
        cyc(2'd0, 6'h00, 1'b0, 1'b0, 1'b1, FAULT,  4'd5, "ill_reset");
        // fetch timeout
        for (int i = 0; i < 16; i++)
            cyc(2'd0, 6'h00, 1'b0, 1'b1, 1'b1, FETCH, 4'd0, "to_fetch_wait");
        for (int i = 0; i < 100; i++)
            cyc(2'd0, 6'h00, 1'b0, 1'b1, 1'b1, FAULT, 4'd0, "to_fault_sticky");
        cyc(2'd0, 6'h00, 1'b0, 1'b0, 1'b1, FAULT,  4'd0, "to_reset");
        // 17 branches wrap the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            cyc(2'd2, 6'h00, 1'b1, 1'b1, 1'b1, FETCH,  4'(i), "br_fetch");
            cyc(2'd2, 6'h00, 1'b0, 1'b1, 1'b1, DECODE, 4'(i), "br_decode");
            cyc(2'd2, 6'h00, 1'b0, 1'b1, 1'b1, BRANCH, 4'(i), "br_branch");
        end
        // reset in MEMWR beats the retire that ready would cause
        cyc(2'd1, 6'h00, 1'b1, 1'b1, 1'b1, FETCH,  4'd1, "wrap_str_fetch");
        cyc(2'd1, 6'h00, 1'b0, 1'b1, 1'b1, DECODE, 4'd1, "rst_str_decode");
        cyc(2'd1, 6'h00, 1'b0, 1'b1, 1'b1, MEMADR, 4'd1, "rst_str_memadr");
        cyc(2'd1, 6'h00, 1'b1, 1'b0, 1'b1, MEMWR,  4'd1, "rst_str_memwr");
        cyc(2'd0, 6'h00, 1'b0, 1'b1, 1'b1, FETCH,  4'd0, "rst_str_after");
        cyc(2'd0, 6'h00, 1'b0, 1'b1, 1'b1, FETCH,  4'd0, "rst_str_hold");
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
